// File: rtl/systolic_pkg.sv
// systolic_pkg: shared state encoding and width helper for the systolic matmul controller
package systolic_pkg;

    typedef enum logic [4:0] {
        IDLE   = 5'b00001,
        LOAD   = 5'b00010,
        SETTLE = 5'b00100,
        DRAIN  = 5'b01000,
        CLEAR  = 5'b10000
    } state_e;

    function automatic int safe_clog2(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/mac_array.sv
// mac_array: rows_p x cols_p multiply-accumulate grid fed by per-row and per-column operand consumers
module mac_array #(
    parameter int width_p = 32,
    parameter int rows_p  = 2,
    parameter int cols_p  = 2
) (
    input  logic                               clk_i,
    input  logic                               reset_ni,
    input  logic                               en_i,
    input  logic                               clear_i,
    input  logic [width_p-1:0]                 data_i,
    input  logic [rows_p-1:0]                  row_v_i,
    input  logic [cols_p-1:0]                  col_v_i,
    output logic [rows_p-1:0]                  row_r_o,
    output logic [cols_p-1:0]                  col_r_o,
    output logic [rows_p*cols_p*width_p-1:0]   z_o
);
    logic [width_p-1:0] a_q [rows_p];
    logic [width_p-1:0] b_q [cols_p];
    logic [width_p-1:0] z_q [rows_p][cols_p];
    logic [rows_p-1:0]  a_full_q;
    logic [cols_p-1:0]  b_full_q;
    logic               fire;

    // Once every row and column holds an operand for this pass, all cells accumulate together.
    assign fire    = en_i & (&a_full_q) & (&b_full_q);
    assign row_r_o = ~a_full_q;
    assign col_r_o = ~b_full_q;

    for (genvar g = 0; g < rows_p * cols_p; g++) begin : g_z
        assign z_o[g*width_p +: width_p] = z_q[g / cols_p][g % cols_p];
    end

    // Operand capture, per-pass release of consumers and wrap-around accumulation.
    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            a_full_q <= '0;
            b_full_q <= '0;
            for (int r = 0; r < rows_p; r++) a_q[r] <= '0;
            for (int c = 0; c < cols_p; c++) b_q[c] <= '0;
            for (int r = 0; r < rows_p; r++) for (int c = 0; c < cols_p; c++) z_q[r][c] <= '0;
        end else if (clear_i) begin
            a_full_q <= '0;
            b_full_q <= '0;
            for (int r = 0; r < rows_p; r++) for (int c = 0; c < cols_p; c++) z_q[r][c] <= '0;
        end else begin
            for (int r = 0; r < rows_p; r++)
                if (fire) a_full_q[r] <= 1'b0;
                else if (row_v_i[r]) begin
                    a_q[r]      <= data_i;
                    a_full_q[r] <= 1'b1;
                end
            for (int c = 0; c < cols_p; c++)
                if (fire) b_full_q[c] <= 1'b0;
                else if (col_v_i[c]) begin
                    b_q[c]      <= data_i;
                    b_full_q[c] <= 1'b1;
                end
            if (fire)
                for (int r = 0; r < rows_p; r++)
                    for (int c = 0; c < cols_p; c++)
                        z_q[r][c] <= z_q[r][c] + a_q[r] * b_q[c];
        end
    end

endmodule

// File: rtl/wrap_counter.sv
// wrap_counter: modulo-max_p counter with synchronous clear and terminal-count flag
module wrap_counter import systolic_pkg::*; #(
    parameter int max_p = 2
) (
    input  logic                          clk_i,
    input  logic                          reset_ni,
    input  logic                          en_i,
    input  logic                          clear_i,
    output logic [safe_clog2(max_p)-1:0]  count_o,
    output logic                          last_o
);
    localparam int w_lp = safe_clog2(max_p);
    localparam logic [w_lp-1:0] last_lp = w_lp'(max_p - 1);

    logic [w_lp-1:0] count_q, count_d;

    assign last_o  = count_q == last_lp;
    assign count_o = count_q;
    assign count_d = clear_i ? '0 : en_i ? (last_o ? '0 : count_q + 1'b1) : count_q;

    // Count register; never leaves 0..max_p-1.
    always_ff @(posedge clk_i or negedge reset_ni)
        if (!reset_ni) count_q <= '0;
        else count_q <= count_d;

endmodule

// File: rtl/systolic_matmul_ctrl.sv
// systolic_matmul_ctrl: steers one operand stream into a mac_array, waits for it to settle and drains results row-major
module systolic_matmul_ctrl import systolic_pkg::*; #(
    parameter int width_p        = 32,
    parameter int array_width_p  = 2,
    parameter int array_height_p = 2,
    parameter int depth_p        = 2
) (
    input  logic                                               clk_i,
    input  logic                                               reset_ni,
    input  logic                                               en_i,
    input  logic                                               abort_i,
    input  logic                                               valid_i,
    input  logic [width_p-1:0]                                 data_i,
    output logic                                               ready_o,
    output logic                                               valid_o,
    output logic [width_p-1:0]                                 data_o,
    output logic [safe_clog2(array_height_p*array_width_p)-1:0] idx_o,
    input  logic                                               yumi_i,
    output logic                                               busy_o
);
    localparam int n_lp     = array_height_p + array_width_p;
    localparam int cells_lp = array_height_p * array_width_p;

    state_e                            state_q;
    logic [safe_clog2(n_lp)-1:0]       sel_cnt, settle_cnt;
    logic [safe_clog2(depth_p)-1:0]    k_cnt;
    logic [safe_clog2(cells_lp)-1:0]   drain_idx;
    logic                              sel_last, k_last, settle_last, drain_last;
    logic [array_height_p-1:0]         row_r;
    logic [array_width_p-1:0]          col_r;
    logic [n_lp-1:0]                   cons_ready, cons_valid;
    logic [cells_lp*width_p-1:0]       z;
    logic [width_p-1:0]                z_arr [cells_lp];
    logic                              live, loading, accept, clear, settle_en, drain_en;
    logic                              unused_cnt;

    // Abort only counts while enabled; it also blocks any beat offered in the same cycle.
    assign live       = en_i & ~abort_i;
    assign loading    = (state_q == IDLE) | (state_q == LOAD);
    assign cons_ready = {col_r, row_r};
    assign ready_o    = reset_ni & live & loading & cons_ready[sel_cnt];
    assign accept     = valid_i & ready_o;
    assign cons_valid = accept ? (n_lp'(1) << sel_cnt) : '0;
    assign clear      = en_i & (state_q == CLEAR);
    assign settle_en  = live & (state_q == SETTLE) & (~settle_last | &cons_ready);
    assign drain_en   = live & (state_q == DRAIN) & yumi_i;
    assign unused_cnt = ^{k_cnt, settle_cnt};

    assign valid_o = state_q == DRAIN;
    assign busy_o  = state_q == SETTLE;
    assign idx_o   = valid_o ? drain_idx : '0;
    assign data_o  = valid_o ? z_arr[drain_idx] : '0;

    for (genvar g = 0; g < cells_lp; g++) begin : g_res
        assign z_arr[g] = z[g*width_p +: width_p];
    end

    wrap_counter #(.max_p(n_lp)) u_sel (
        .clk_i(clk_i), .reset_ni(reset_ni), .en_i(accept), .clear_i(clear),
        .count_o(sel_cnt), .last_o(sel_last)
    );

    wrap_counter #(.max_p(depth_p)) u_k (
        .clk_i(clk_i), .reset_ni(reset_ni), .en_i(accept & sel_last), .clear_i(clear),
        .count_o(k_cnt), .last_o(k_last)
    );

    wrap_counter #(.max_p(n_lp)) u_settle (
        .clk_i(clk_i), .reset_ni(reset_ni), .en_i(settle_en), .clear_i(clear),
        .count_o(settle_cnt), .last_o(settle_last)
    );

    wrap_counter #(.max_p(cells_lp)) u_drain (
        .clk_i(clk_i), .reset_ni(reset_ni), .en_i(drain_en), .clear_i(clear),
        .count_o(drain_idx), .last_o(drain_last)
    );

    mac_array #(.width_p(width_p), .rows_p(array_height_p), .cols_p(array_width_p)) u_array (
        .clk_i(clk_i), .reset_ni(reset_ni), .en_i(en_i), .clear_i(clear), .data_i(data_i),
        .row_v_i(cons_valid[array_height_p-1:0]), .col_v_i(cons_valid[n_lp-1:array_height_p]),
        .row_r_o(row_r), .col_r_o(col_r), .z_o(z)
    );

    // Job sequencing; abort outranks every other transition and nothing moves while disabled.
    always_ff @(posedge clk_i or negedge reset_ni)
        if (!reset_ni) state_q <= IDLE;
        else if (en_i) begin
            if (abort_i && state_q != CLEAR) state_q <= CLEAR;
            else case (state_q)
                IDLE, LOAD: if (accept) state_q <= (sel_last && k_last) ? SETTLE : LOAD;
                SETTLE:     if (settle_last && &cons_ready) state_q <= DRAIN;
                DRAIN:      if (yumi_i && drain_last) state_q <= CLEAR;
                CLEAR:      state_q <= IDLE;
                default:    state_q <= IDLE;
            endcase
        end

endmodule
